// File: rtl/pc_unit_ras.sv
// -----------------------------------------------------------------------------
// pc_unit_ras
//   Program-counter unit with a circular return-address stack (RAS).
//   Holds the fetch PC and selects the next PC from one of these sources:
//   sequential (pc+4), branch/jal target, computed jalr target, or RAS top.
//   A flush redirects the PC and takes priority over both stall and pc_src.
//
// Parameters
//   PC_WIDTH     : PC / address width (>= 8)
//   RESET_VECTOR : PC after reset (4-byte aligned)
//   RAS_DEPTH    : RAS entries (power of 2, >= 2)
//
// Ports
//   clk, rst        : clock, async active-high reset
//   stall           : hold PC, RAS and misalign
//   flush           : load flush_target; RAS ops suppressed
//   flush_target    : redirect address
//   pc_src          : 00 inc_pc, 01 pc_target, 10 return_addr, 11 RAS top
//   pc_target       : branch / jal target
//   return_addr     : jalr target (low PC_WIDTH bits used)
//   ras_push        : push inc_pc (call)
//   ras_pop         : pop (return)
//   pc              : registered fetch PC
//   inc_pc          : pc + 4
//   ras_top         : top-of-stack entry, 0 when empty
//   ras_count       : number of valid entries
//   ras_overflow    : sticky, push while full
//   ras_underflow   : sticky, pop/return while empty
//   misalign        : one-cycle pulse, last loaded source had bits [1:0] != 0
// -----------------------------------------------------------------------------
module pc_unit_ras #(
   parameter int                    PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
   parameter int                    RAS_DEPTH    = 8,
   localparam int                   PTR_W        = $clog2(RAS_DEPTH),
   localparam int                   CNT_W        = PTR_W + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic [PC_WIDTH-1:0] flush_target,
   input  logic [1:0]          pc_src,
   input  logic [PC_WIDTH-1:0] pc_target,
   input  logic [31:0]         return_addr,
   input  logic                ras_push,
   input  logic                ras_pop,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] inc_pc,
   output logic [PC_WIDTH-1:0] ras_top,
   output logic [CNT_W-1:0]    ras_count,
   output logic                ras_overflow,
   output logic                ras_underflow,
   output logic                misalign
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

   logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]    tp;
   logic [PC_WIDTH-1:0] ret_pc;
   logic [PC_WIDTH-1:0] raw_next;
   logic [PC_WIDTH-1:0] next_pc;
   logic                ras_empty, ras_full;
   logic                load_en, op_en;
   logic                do_push, do_pop;
   logic                swap_top;     // push+pop on a non-empty stack
   logic                push_adv;     // push that advances tp
   logic                ret_fallback; // pc_src=11 on an empty stack

   // jalr target: truncate or zero-extend the 32-bit value to PC_WIDTH
   generate
      if (PC_WIDTH <= 32) begin : g_ret_trunc
         assign ret_pc = return_addr[PC_WIDTH-1:0];
         if (PC_WIDTH < 32) begin : g_ret_hi
            logic unused_ret_hi;
            assign unused_ret_hi = |return_addr[31:PC_WIDTH];
         end
      end else begin : g_ret_ext
         assign ret_pc = {{(PC_WIDTH-32){1'b0}}, return_addr};
      end
   endgenerate

   assign inc_pc    = pc + PC_WIDTH'(4);
   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == FULL_CNT);
   assign ras_top   = ras_empty ? '0 : ras_mem[tp];

   // flush overrides stall; RAS only moves when neither is active
   assign load_en = flush | ~stall;
   assign op_en   = ~flush & ~stall;
   assign do_push = op_en & ras_push;
   assign do_pop  = op_en & ras_pop;

   assign swap_top     = do_push & do_pop & ~ras_empty;
   assign push_adv     = do_push & ~swap_top;
   assign ret_fallback = op_en & (pc_src == 2'b11) & ras_empty;

   // Next-PC select; RAS top is the pre-update value even when pushing
   always_comb begin
      raw_next = inc_pc;
      if (flush) begin
         raw_next = flush_target;
      end else begin
         case (pc_src)
            2'b00:   raw_next = inc_pc;
            2'b01:   raw_next = pc_target;
            2'b10:   raw_next = ret_pc;
            default: raw_next = ras_empty ? ret_pc : ras_top;
         endcase
      end
   end

   assign next_pc = {raw_next[PC_WIDTH-1:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= RESET_VECTOR;
         misalign      <= 1'b0;
         tp            <= '0;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         if (load_en) begin
            pc       <= next_pc;
            misalign <= |raw_next[1:0];
         end

         if (ret_fallback)
            ras_underflow <= 1'b1;

         if (push_adv) begin
            tp <= tp + PTR_W'(1);
            // Full: wrap onto the oldest entry and keep the count saturated
            if (ras_full)
               ras_overflow <= 1'b1;
            else
               ras_count <= ras_count + CNT_W'(1);
            // Push+pop on an empty stack degenerates to a push
            if (do_pop)
               ras_underflow <= 1'b1;
         end else if (do_pop && !do_push) begin
            if (ras_empty) begin
               ras_underflow <= 1'b1;
            end else begin
               tp        <= tp - PTR_W'(1);
               ras_count <= ras_count - CNT_W'(1);
            end
         end
      end
   end

   // Entry storage is not reset; contents past ras_count are never observed
   always_ff @(posedge clk) begin
      if (push_adv)
         ras_mem[tp + PTR_W'(1)] <= inc_pc;
      else if (swap_top)
         ras_mem[tp] <= inc_pc;
   end

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;
   localparam int          PW    = 16;
   localparam int          DEPTH = 4;
   localparam logic [15:0] RV    = 16'h0100;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall, flush;
   logic [PW-1:0] flush_target, pc_target;
   logic [1:0]    pc_src;
   logic [31:0]   return_addr;
   logic          ras_push, ras_pop;
   logic [PW-1:0] pc, inc_pc, ras_top;
   logic [2:0]    ras_count;
   logic          ras_overflow, ras_underflow, misalign;

   pc_unit_ras #(.PC_WIDTH(PW), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .flush_target(flush_target), .pc_src(pc_src), .pc_target(pc_target),
      .return_addr(return_addr), .ras_push(ras_push), .ras_pop(ras_pop),
      .pc(pc), .inc_pc(inc_pc), .ras_top(ras_top), .ras_count(ras_count),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: the RAS is a plain queue, oldest entry at the front
   logic [PW-1:0] m_pc;
   logic [PW-1:0] m_q[$];
   bit            m_ov, m_uf, m_mis;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RV; m_q.delete(); m_ov = 0; m_uf = 0; m_mis = 0;
   endtask

   task automatic model_step();
      logic [PW-1:0] raw, inc;
      inc = m_pc + 16'd4;
      if (!flush && stall) return;
      if (flush) begin
         raw = flush_target;
      end else begin
         case (pc_src)
            2'd0: raw = inc;
            2'd1: raw = pc_target;
            2'd2: raw = return_addr[PW-1:0];
            default: begin
               if (m_q.size() > 0) raw = m_q[$];
               else begin raw = return_addr[PW-1:0]; m_uf = 1; end
            end
         endcase
         if (ras_push && ras_pop && m_q.size() > 0) begin
            m_q[m_q.size()-1] = inc;
         end else if (ras_push) begin
            if (ras_pop) m_uf = 1;
            if (m_q.size() == DEPTH) begin
               void'(m_q.pop_front());
               m_ov = 1;
            end
            m_q.push_back(inc);
         end else if (ras_pop) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_uf = 1;
         end
      end
      m_pc  = {raw[PW-1:2], 2'b00};
      m_mis = |raw[1:0];
   endtask

   task automatic check_all(input string tag);
      logic [PW-1:0] e_top;
      e_top = (m_q.size() > 0) ? m_q[$] : '0;
      check({tag, ".pc"},     32'(pc),            32'(m_pc));
      check({tag, ".inc"},    32'(inc_pc),        32'(PW'(m_pc + 16'd4)));
      check({tag, ".top"},    32'(ras_top),       32'(e_top));
      check({tag, ".cnt"},    32'(ras_count),     32'(m_q.size()));
      check({tag, ".ovf"},    32'(ras_overflow),  32'(m_ov));
      check({tag, ".udf"},    32'(ras_underflow), 32'(m_uf));
      check({tag, ".mis"},    32'(misalign),      32'(m_mis));
   endtask

   task automatic drv(input logic st, input logic fl, input logic [PW-1:0] ft,
                      input logic [1:0] src, input logic [PW-1:0] tgt,
                      input logic [31:0] ret, input logic pu, input logic po);
      stall = st; flush = fl; flush_target = ft; pc_src = src;
      pc_target = tgt; return_addr = ret; ras_push = pu; ras_pop = po;
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   logic [PW-1:0] pop_tops [4];

   initial begin
      pop_tops[0] = 16'h14; pop_tops[1] = 16'h10;
      pop_tops[2] = 16'h0C; pop_tops[3] = 16'h08;

      rst = 1'b1;
      drv(0, 0, '0, 2'd0, '0, '0, 0, 0);
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // sequential fetch
      for (int i = 0; i < 3; i++) cycle("seq");
      check("seq_end", 32'(pc), 32'h010C);

      // call / return
      drv(0, 1, 16'h0200, 2'd0, '0, '0, 0, 0); cycle("goto200");
      drv(0, 0, '0, 2'd1, 16'h0400, '0, 1, 0); cycle("call");
      check("call_top", 32'(ras_top), 32'h0204);
      drv(0, 0, '0, 2'd3, '0, '0, 0, 1);       cycle("ret");
      check("ret_pc", 32'(pc), 32'h0204);

      // overflow: five pushes from pc 0
      drv(0, 1, 16'h0000, 2'd0, '0, '0, 0, 0); cycle("goto0");
      drv(0, 0, '0, 2'd0, '0, '0, 1, 0);
      for (int i = 0; i < 5; i++) cycle("push");
      check("ovf_cnt", 32'(ras_count), 32'd4);
      check("ovf_flag", 32'(ras_overflow), 32'd1);
      drv(0, 0, '0, 2'd0, '0, '0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         check("pop_top", 32'(ras_top), 32'(pop_tops[i]));
         cycle("pop");
      end

      // underflow fallback, upper return_addr bits dropped
      drv(0, 0, '0, 2'd3, '0, 32'hABCD_3000, 0, 0); cycle("udf");
      check("udf_pc", 32'(pc), 32'h3000);

      // stall then stall+flush
      drv(1, 0, '0, 2'd1, 16'h0500, '0, 1, 0);         cycle("stall");
      drv(1, 1, 16'h0080, 2'd1, 16'h0500, '0, 1, 0);   cycle("stflush");
      check("flush_pc", 32'(pc), 32'h0080);

      // misalign pulse and wrap
      drv(0, 0, '0, 2'd1, 16'h0403, '0, 0, 0); cycle("mis");
      check("mis_pc", 32'(pc), 32'h0400);
      drv(0, 0, '0, 2'd0, '0, '0, 0, 0);       cycle("mis_clr");
      drv(0, 1, 16'hFFFC, 2'd0, '0, '0, 0, 0); cycle("gotoFFFC");
      drv(0, 0, '0, 2'd0, '0, '0, 0, 0);       cycle("wrap");
      check("wrap_pc", 32'(pc), 32'h0000);

      // push+pop swap and empty push+pop
      drv(0, 0, '0, 2'd0, '0, '0, 1, 1); cycle("pp_empty");
      drv(0, 0, '0, 2'd3, '0, '0, 1, 1); cycle("pp_swap");

      // asynchronous reset mid-operation, push held during reset
      drv(0, 0, '0, 2'd1, 16'h0600, '0, 1, 0); cycle("pre_rst");
      #2 rst = 1'b1;
      #1 model_reset();
      check_all("async_rst");
      @(posedge clk); #1;
      check_all("rst_hold");
      @(negedge clk);
      rst = 1'b0;

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drv($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             PW'($urandom), 2'($urandom), PW'($urandom), $urandom,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
